// File: rtl/scurve_sweep_scheduler.sv
// rtl/scurve_sweep_scheduler.sv - DAC0 threshold S-curve scan sequencer
// Loads each DAC0 point, counts injections/triggers, and writes 3-word records plus a tail marker.
module scurve_sweep_scheduler #(
    parameter logic [15:0] SETTLE_CYCLES = 16'd400,
    parameter logic [15:0] TAIL_WORD     = 16'hFF45
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SweepStart,
    input  logic        SweepStop,
    input  logic [9:0]  StartDAC0,
    input  logic [9:0]  EndDAC0,
    input  logic [9:0]  DACStep,
    input  logic [15:0] MaxCountNumber,
    input  logic        CTest_Pulse,
    input  logic        Trigger,
    output logic [9:0]  OutDAC0,
    output logic        LoadSCParameter,
    input  logic        MicrorocConfigDone,
    output logic [15:0] SCurveData,
    output logic        SCurveData_en,
    input  logic        DataFifoFull,
    output logic        SweepBusy,
    output logic        ACQDone,
    input  logic        DataTransmitDone
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_SC,
        S_WAIT_CFG,
        S_SETTLE,
        S_COUNT,
        S_WR_HDR,
        S_WR_TRIG,
        S_WR_PULSE,
        S_NEXT,
        S_WR_TAIL,
        S_DONE
    } state_t;

    state_t      state;
    logic        start_q1;
    logic        start_q2;
    logic        start_pulse;
    logic [9:0]  end_dac;
    logic [9:0]  step_dac;
    logic [15:0] max_cnt;
    logic [15:0] settle_cnt;
    logic [15:0] pulse_cnt;
    logic [15:0] trig_cnt;
    logic        acq_arm;
    logic [10:0] next_dac;
    logic [15:0] pulse_inc;

    assign start_pulse = start_q1 & ~start_q2;
    // 11-bit sum so a step past 1023 ends the scan instead of wrapping to a low DAC
    assign next_dac    = {1'b0, OutDAC0} + {1'b0, step_dac};
    assign pulse_inc   = pulse_cnt + 16'd1;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
        end else begin
            start_q1 <= SweepStart;
            start_q2 <= start_q1;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            OutDAC0         <= 10'd0;
            LoadSCParameter <= 1'b0;
            SCurveData      <= 16'd0;
            SCurveData_en   <= 1'b0;
            SweepBusy       <= 1'b0;
            ACQDone         <= 1'b0;
            end_dac         <= 10'd0;
            step_dac        <= 10'd0;
            max_cnt         <= 16'd0;
            settle_cnt      <= 16'd0;
            pulse_cnt       <= 16'd0;
            trig_cnt        <= 16'd0;
            acq_arm         <= 1'b0;
        end else begin
            LoadSCParameter <= 1'b0;
            SCurveData_en   <= 1'b0;
            ACQDone         <= 1'b0;
            if (SweepStop && state != S_IDLE) begin
                state     <= S_IDLE;
                SweepBusy <= 1'b0;
                acq_arm   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_pulse) begin
                            OutDAC0   <= StartDAC0;
                            end_dac   <= EndDAC0;
                            step_dac  <= (DACStep == 10'd0) ? 10'd1 : DACStep;
                            max_cnt   <= (MaxCountNumber == 16'd0) ? 16'd1 : MaxCountNumber;
                            SweepBusy <= 1'b1;
                            state     <= S_LOAD_SC;
                        end
                    end
                    S_LOAD_SC: begin
                        LoadSCParameter <= 1'b1;
                        state           <= S_WAIT_CFG;
                    end
                    S_WAIT_CFG: begin
                        if (MicrorocConfigDone) begin
                            settle_cnt <= 16'd0;
                            state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_CYCLES - 16'd1) begin
                            pulse_cnt <= 16'd0;
                            trig_cnt  <= 16'd0;
                            state     <= S_COUNT;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end
                    S_COUNT: begin
                        if (Trigger && trig_cnt != 16'hFFFF) begin
                            trig_cnt <= trig_cnt + 16'd1;
                        end
                        if (CTest_Pulse) begin
                            pulse_cnt <= pulse_inc;
                            if (pulse_inc == max_cnt) begin
                                state <= S_WR_HDR;
                            end
                        end
                    end
                    S_WR_HDR: begin
                        if (!DataFifoFull) begin
                            SCurveData    <= {6'b110000, OutDAC0};
                            SCurveData_en <= 1'b1;
                            state         <= S_WR_TRIG;
                        end
                    end
                    S_WR_TRIG: begin
                        if (!DataFifoFull) begin
                            SCurveData    <= trig_cnt;
                            SCurveData_en <= 1'b1;
                            state         <= S_WR_PULSE;
                        end
                    end
                    S_WR_PULSE: begin
                        if (!DataFifoFull) begin
                            SCurveData    <= pulse_cnt;
                            SCurveData_en <= 1'b1;
                            state         <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (next_dac[10] || next_dac[9:0] > end_dac) begin
                            state <= S_WR_TAIL;
                        end else begin
                            OutDAC0 <= next_dac[9:0];
                            state   <= S_LOAD_SC;
                        end
                    end
                    S_WR_TAIL: begin
                        if (!DataFifoFull) begin
                            SCurveData    <= TAIL_WORD;
                            SCurveData_en <= 1'b1;
                            acq_arm       <= 1'b1;
                            state         <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // acq_arm makes ACQDone a single pulse right after the tail write
                        ACQDone <= acq_arm;
                        acq_arm <= 1'b0;
                        if (DataTransmitDone) begin
                            SweepBusy <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        SweepBusy <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/scurve_sweep_scheduler.md
# scurve_sweep_scheduler

Sequences a threshold (DAC0) S-curve scan of the Microroc front end. For each DAC0 point it loads the slow-control value and waits for configuration to finish. It then counts charge-injection pulses and triggers over a fixed number of injections and writes a 3-word record into the downstream USB data FIFO. It sits beside the sweep acquisition path, shares its slow-control load handshake, and drives the same output FIFO write port.

## Interface
- SETTLE_CYCLES, 16'd400: idle clocks between MicrorocConfigDone and opening the count window (must be ≥1).
- TAIL_WORD, 16'hFF45: end-of-scan marker word.
- Clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- SweepStart  input  1  level; a scan starts on its rising edge.
- SweepStop  input  1  level; abort when high.
- StartDAC0  input  10  first DAC0 value.
- EndDAC0  input  10  last allowed DAC0 value.
- DACStep  input  10  DAC0 increment; 0 is treated as 1.
- MaxCountNumber  input  16  injections per point; 0 is treated as 1.
- CTest_Pulse  input  1  single-cycle strobe, one per charge injection.
- Trigger  input  1  single-cycle synchronized hit strobe.
- OutDAC0  output  10  DAC0 to slow control.
- LoadSCParameter  output  1  one-cycle slow-control load request.
- MicrorocConfigDone  input  1  single-cycle pulse: configuration finished.
- SCurveData  output  16  FIFO write data.
- SCurveData_en  output  1  FIFO write strobe.
- DataFifoFull  input  1  backpressure; no write while high.
- SweepBusy  output  1  high in every non-IDLE state.
- ACQDone  output  1  one-cycle pulse after the tail word is written.
- DataTransmitDone  input  1  host has drained data; releases DONE.

## Operation
- Start detect: two-flop edge detect. Start pulse = reg1 & ~reg2. FSM leaves IDLE on the cycle the pulse is seen.
- On start, latch StartDAC0, EndDAC0, DACStep and MaxCountNumber. Later input changes are ignored until the next scan.
- States and transitions:
  - IDLE → LOAD_SC.
  - LOAD_SC: LoadSCParameter=1 for exactly one cycle → WAIT_CFG.
  - WAIT_CFG: on MicrorocConfigDone → SETTLE. No timeout.
  - SETTLE: count SETTLE_CYCLES clocks → COUNT.
  - COUNT: ends when the injection count reaches the latched max → WR_HDR.
  - WR_HDR → WR_TRIG → WR_PULSE → NEXT.
  - NEXT → LOAD_SC, or → WR_TAIL → DONE.
  - DONE: on DataTransmitDone → IDLE.
- COUNT:
  - Pulse counter and trigger counter clear on entry.
  - Each CTest_Pulse increments the pulse counter; each Trigger increments the trigger counter, saturating at 16'hFFFF.
  - A Trigger coincident with the final CTest_Pulse is counted.
  - Strobes outside COUNT are ignored.
- Record words, in order:
  - {6'b110000, OutDAC0}
  - trigger count
  - pulse count
- Point sequence: Start, Start+Step, … while ≤ End.
  - Next value is computed in 11 bits. If it exceeds End or 1023, the scan finishes.
  - StartDAC0 > EndDAC0 gives exactly one point at StartDAC0.
- WR_TAIL writes TAIL_WORD. ACQDone pulses in the cycle after that write.
- SweepStop high in any non-IDLE state: next cycle is IDLE.
  - No tail word, no ACQDone.
  - A pending write is dropped.
  - OutDAC0 holds its value.
- SweepStart held high does not restart a scan. A new rising edge is required after IDLE.

## Timing
- Reset values: OutDAC0=0, LoadSCParameter=0, SCurveData=0, SCurveData_en=0, SweepBusy=0, ACQDone=0. FSM in IDLE, counters 0.
- OutDAC0 is registered and updated on entry to LOAD_SC. It is stable in the cycle LoadSCParameter=1 and held until the next LOAD_SC.
- Start latency: SweepStart rises at edge k, LoadSCParameter=1 at edge k+3.
- Each write state asserts SCurveData_en for one cycle when DataFifoFull=0, then advances. While DataFifoFull=1 it holds with en=0 and data stable.
- Writes are back-to-back when the FIFO is not full: 3 consecutive cycles per record.
- Config to count: the count window opens SETTLE_CYCLES+1 cycles after MicrorocConfigDone.
- Asynchronous reset mid-scan: everything returns to reset values immediately. No write completes after reset asserts.

## Test plan
- Start=100, End=102, Step=1, Max=10, 10 pulses and 4 triggers per point.
  - Expect words C064,0004,000A, C065,0004,000A, C066,0004,000A, then FF45.
  - Expect one ACQDone pulse.
  - Expect three LoadSCParameter pulses with OutDAC0 = 100, 101, 102.
- Start=1020, End=1023, Step=5: exactly one record (DAC 1020), then tail. No wrap to a low DAC.
- Max=0: the window closes after 1 pulse, pulse count word = 0001. A Trigger coincident with that pulse gives trigger count = 0001.
- DataFifoFull held high for 20 cycles during WR_TRIG: en=0 throughout, data stable. After release, writes resume and the record is intact.
- SweepStop asserted in COUNT at point 2: IDLE next cycle, SweepBusy=0, no FF45 written, no ACQDone. A new SweepStart edge rescans from StartDAC0.
- reset_n low during WR_HDR: all outputs 0 immediately. After release the FSM stays in IDLE until a fresh SweepStart edge.
